full_adder_structural: RTL and testbench
========================================

Name: full_adder_structural

Overview:
- Gate-level (structural) binary adder: WIDTH-bit ripple chain of 1-bit full-adder cells, each built from XOR/AND/OR primitives only.
- Combinational sum/carry outputs plus a registered copy for pipelined consumers.
- Default WIDTH=1 makes it a classic single-bit full adder.
- Used as the arithmetic leaf cell in datapath blocks.

Parameters:
- WIDTH, 1, operand/sum bit width (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock; used by the registered outputs only.
- rst  input  1  synchronous, active-high reset; clears the registered outputs only.
- a  input  WIDTH  operand A, unsigned (two's-complement view used for overflow only).
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- sum  output  WIDTH  combinational sum, a+b+carry_in modulo 2^WIDTH.
- carry_out  output  1  combinational carry out of the MSB cell.
- overflow  output  1  combinational signed overflow, carry into MSB XOR carry out of MSB.
- sum_q  output  WIDTH  sum registered on clk.
- carry_out_q  output  1  carry_out registered on clk.
- overflow_q  output  1  overflow registered on clk.

Behaviour:
- Cell i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = carry_in.
- Cells are gate primitives or continuous-assign gate expressions, instantiated by a generate loop. No behavioural '+' is used anywhere in the module.
- Combinational outputs:
  - {carry_out, sum} = a + b + carry_in exactly, zero latency, for all 2^(2*WIDTH+1) input combinations.
  - No dependence on clk or rst.
  - Settle within the same delta and timestep as an input change; no inertial delays are modelled.
- overflow = c_(WIDTH-1) ^ c_WIDTH. At WIDTH=1 it equals carry_in ^ carry_out.
- Registered outputs:
  - On each rising clk with rst=1: sum_q=0, carry_out_q=0, overflow_q=0.
  - On each rising clk with rst=0: they capture the current combinational sum, carry_out and overflow. Latency is 1 cycle, with no enable.
- Reset:
  - Synchronous only; asserting rst between edges has no effect until the next edge.
  - Registered outputs are X from time 0 until the first clocked edge.
  - rst never affects the combinational path, so sum and carry_out stay valid during reset.
- Boundaries:
  - All-ones + all-ones + 1 gives sum = all-ones, carry_out=1.
  - All-zeros with carry_in=0 gives all zeros.
  - Wrap-around is modulo 2^WIDTH; the lost bit appears on carry_out.
- Inputs with X/Z propagate X through the gates. This is not a defined operating mode.

Test Plan:
1. WIDTH=1, exhaustive truth table: apply (a,b,carry_in) = 000,001,010,011,100,101,110,111, 1 time unit apart, no clock. Required response:
   - sum = 0,1,1,0,1,0,0,1.
   - carry_out = 0,0,0,1,0,1,1,1.
2. WIDTH=1, registered path: apply a=1, b=1, carry_in=1 with rst=0, then one clk edge -> sum_q=1, carry_out_q=1, overflow_q=0.
3. Reset: hold rst=1 for 2 edges with a=1, b=1, carry_in=1:
   - sum_q=0, carry_out_q=0, overflow_q=0.
   - Meanwhile combinational sum=1, carry_out=1.
   - Drop rst; after the next edge, sum_q=1.
4. WIDTH=8, carry ripple: a=8'hFF, b=8'h00, carry_in=1 -> sum=8'h00, carry_out=1, overflow=0.
5. WIDTH=8, signed overflow: a=8'h7F, b=8'h01, carry_in=0 -> sum=8'h80, carry_out=0, overflow=1. Then a=8'h80, b=8'h80 -> sum=8'h00, carry_out=1, overflow=1.
6. WIDTH=8, random check: 10,000 random (a, b, carry_in) vectors. Compare {carry_out, sum} against a reference a+b+carry_in. Check that sum_q/carry_out_q equal the previous cycle's combinational values.

Source files
------------

// File: rtl/full_adder_structural.sv
// full_adder_structural: WIDTH-bit ripple-carry adder assembled from 1-bit
// full-adder cells expressed purely as XOR/AND/OR gate equations. The
// combinational sum, carry and signed-overflow outputs are also registered
// on clk for consumers that want a pipelined copy.
`timescale 1ns/1ps

module full_adder_structural #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic [WIDTH-1:0] sum_q,
   output logic             carry_out_q,
   output logic             overflow_q
);

   // c[i] is the carry into cell i; c[WIDTH] leaves the MSB cell.
   logic [WIDTH:0] c;

   assign c[0] = carry_in;

   // One full-adder cell per bit, rippling the carry upward.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic p;  // propagate: a ^ b
      logic g;  // generate:  a & b
      logic t;  // carry passed through when propagating

      assign p        = a[i] ^ b[i];
      assign g        = a[i] & b[i];
      assign t        = c[i] & p;
      assign sum[i]   = p ^ c[i];
      assign c[i+1]   = g | t;
   end

   assign carry_out = c[WIDTH];

   // Signed overflow: the carry into the sign bit disagrees with the carry
   // out of it. At WIDTH=1 the carry into the sign bit is carry_in itself.
   assign overflow  = c[WIDTH-1] ^ c[WIDTH];

   // Registered copy of the combinational results; reset is synchronous and
   // only touches these flops, never the combinational path above.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         sum_q       <= sum;
         carry_out_q <= carry_out;
         overflow_q  <= overflow;
      end
   end

endmodule

// File: tb/tb_full_adder_structural.sv
// Self-checking bench for full_adder_structural at WIDTH=1 and WIDTH=8.
`timescale 1ns/1ps

module tb_full_adder_structural;

   logic       clk = 1'b0;
   logic       rst;
   logic [0:0] a1, b1;
   logic       cin1;
   logic [0:0] sum1, sum_q1;
   logic       co1, ov1, co_q1, ov_q1;
   logic [7:0] a8, b8;
   logic       cin8;
   logic [7:0] sum8, sum_q8;
   logic       co8, ov8, co_q8, ov_q8;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;
   bit q_ok        = 1'b0;
   logic [9:0] exp_q1, exp_q8;

   always #10 clk = ~clk;

   full_adder_structural #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .carry_in(cin1),
      .sum(sum1), .carry_out(co1), .overflow(ov1),
      .sum_q(sum_q1), .carry_out_q(co_q1), .overflow_q(ov_q1)
   );

   full_adder_structural #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .carry_in(cin8),
      .sum(sum8), .carry_out(co8), .overflow(ov8),
      .sum_q(sum_q8), .carry_out_q(co_q8), .overflow_q(ov_q8)
   );

   // Reference: {overflow, carry_out, sum[7:0]} from plain integer arithmetic.
   // Overflow is judged by whether the signed sum leaves the signed range.
   function automatic logic [9:0] model(input int w, input int av, input int bv, input int cv);
      int tot, sa, sb, st, lim;
      bit ov, co;
      logic [7:0] s;
      tot = av + bv + cv;
      s   = 8'(tot % (1 << w));
      co  = ((tot >> w) & 1) != 0;
      sa  = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
      sb  = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
      st  = sa + sb + cv;
      lim = 1 << (w - 1);
      ov  = (st > lim - 1) || (st < -lim);
      return {ov, co, s};
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   // Expected registered values, captured from the model at each rising edge.
   always @(posedge clk) begin
      exp_q1 <= rst ? 10'd0 : model(1, int'(a1), int'(b1), int'(cin1));
      exp_q8 <= rst ? 10'd0 : model(8, int'(a8), int'(b8), int'(cin8));
      q_ok   <= 1'b1;
   end

   // Per-cycle compare of both instances against the model.
   always @(negedge clk) begin
      logic [9:0] m1, m8;
      if (chk_en) begin
         m1 = model(1, int'(a1), int'(b1), int'(cin1));
         m8 = model(8, int'(a8), int'(b8), int'(cin8));
         chk("w1_sum", 16'(sum1), 16'(m1[0]));
         chk("w1_cout_ovf", 16'({co1, ov1}), 16'({m1[8], m1[9]}));
         chk("w8_sum", 16'(sum8), 16'(m8[7:0]));
         chk("w8_cout_ovf", 16'({co8, ov8}), 16'({m8[8], m8[9]}));
         if (q_ok) begin
            chk("w1_reg", 16'({ov_q1, co_q1, sum_q1}), 16'({exp_q1[9:8], exp_q1[0]}));
            chk("w8_reg", 16'({ov_q8, co_q8, sum_q8}), 16'(exp_q8));
         end
      end
   end

   initial begin
      logic [7:0] exp_s, exp_c;
      logic [2:0] v;
      logic [9:0] m;
      rst = 1'b0;
      a1 = '0; b1 = '0; cin1 = 1'b0;
      a8 = '0; b8 = '0; cin8 = 1'b0;
      exp_s = 8'b1001_0110;
      exp_c = 8'b1110_1000;

      // WIDTH=1 truth table, one unit apart, literal expectations.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         {a1, b1, cin1} = v;
         #1;
         chk($sformatf("tt_sum_%0d", i), 16'(sum1), 16'(exp_s[i]));
         chk($sformatf("tt_cout_%0d", i), 16'(co1), 16'(exp_c[i]));
         chk($sformatf("tt_ovf_%0d", i), 16'(ov1), 16'(cin1 ^ exp_c[i]));
      end

      // Pin the model itself against hand-computed values.
      m = model(8, 'hFF, 'h00, 1); chk("model_ripple", 16'(m), 16'({1'b0, 1'b1, 8'h00}));
      m = model(8, 'h7F, 'h01, 0); chk("model_ovf_pos", 16'(m), 16'({1'b1, 1'b0, 8'h80}));
      m = model(1, 1, 1, 1);       chk("model_w1_111", 16'(m), 16'({1'b0, 1'b1, 8'h01}));

      // Registered path.
      @(negedge clk); #1;
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; rst = 1'b0;
      @(posedge clk); #1;
      chk("reg_w1_111", 16'({sum_q1, co_q1, ov_q1}), 16'(3'b110));

      // Synchronous reset held for two edges; combinational path unaffected.
      @(negedge clk); #1;
      rst = 1'b1;
      chk("rst_async_free", 16'(sum_q1), 16'(1));
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk($sformatf("rst_q_%0d", k), 16'({sum_q1, co_q1, ov_q1}), 16'(0));
         chk($sformatf("rst_comb_%0d", k), 16'({sum1, co1}), 16'(3));
      end
      @(negedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_release", 16'(sum_q1), 16'(1));

      // WIDTH=8 directed boundaries.
      @(negedge clk); #1;
      a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; #1;
      chk("w8_ripple", 16'({ov8, co8, sum8}), 16'({1'b0, 1'b1, 8'h00}));
      a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; #1;
      chk("w8_ovf_pos", 16'({ov8, co8, sum8}), 16'({1'b1, 1'b0, 8'h80}));
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; #1;
      chk("w8_ovf_neg", 16'({ov8, co8, sum8}), 16'({1'b1, 1'b1, 8'h00}));
      a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #1;
      chk("w8_all_ones", 16'({co8, sum8}), 16'({1'b1, 8'hFF}));
      a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; #1;
      chk("w8_all_zero", 16'({ov8, co8, sum8}), 16'(0));

      // Random phase with occasional reset; checked every cycle by the
      // compare process above.
      @(negedge clk); #1;
      chk_en = 1'b1;
      repeat (10000) begin
         @(negedge clk); #1;
         a8   = 8'($urandom);
         b8   = 8'($urandom);
         cin8 = 1'($urandom);
         a1   = 1'($urandom);
         b1   = 1'($urandom);
         cin1 = 1'($urandom);
         rst  = ($urandom_range(0, 31) == 0);
      end
      @(negedge clk); #1;
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
